// File: rtl/disp_pkg.sv
// Shared definitions for the two-digit multiplexed 7-segment display path.
// Segment codes are active-low, with bit 6 = CA down to bit 0 = CG.
package disp_pkg;

    typedef enum logic [1:0] {
        LO_DEAD = 2'd0,
        LO_ON   = 2'd1,
        HI_DEAD = 2'd2,
        HI_ON   = 2'd3
    } disp_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [0:15][6:0] SEG_TABLE = {
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low 7-segment pattern.
module seg7_hex_decode
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_disp_scheduler.sv
// Two-digit display time-multiplexer with dead-time slots and frame-boundary
// commit of new digit pairs via a load/acknowledge handshake.
module seg_disp_scheduler
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 4,
    parameter int TMR_W       = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Ld,
    input  logic [3:0] DigHi,
    input  logic [3:0] DigLo,
    input  logic       Blank,
    input  logic       LzBlank,
    output logic       Ack,
    output logic       SegSel,
    output logic [6:0] Seg
);

    localparam logic [TMR_W-1:0] DEAD_LAST = TMR_W'(DEAD_CYC - 1);
    localparam logic [TMR_W-1:0] ON_LAST   = TMR_W'(REFRESH_DIV - DEAD_CYC - 1);

    disp_state_e      st, st_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [3:0]       com_hi, com_lo;
    logic [3:0]       pend_hi, pend_lo;
    logic             pend;
    logic             slot_end;
    logic             commit;
    logic             nxt_hi;
    logic             nxt_on;
    logic             seg_off;
    logic [3:0]       dig_show;
    logic [6:0]       dig_seg;

    seg7_hex_decode u_dec (
        .hex (dig_show),
        .seg (dig_seg)
    );

    always_comb begin
        st_nxt   = st;
        slot_end = 1'b0;
        case (st)
            LO_DEAD: begin
                slot_end = (tmr == DEAD_LAST);
                if (slot_end) st_nxt = LO_ON;
            end
            LO_ON: begin
                slot_end = (tmr == ON_LAST);
                if (slot_end) st_nxt = HI_DEAD;
            end
            HI_DEAD: begin
                slot_end = (tmr == DEAD_LAST);
                if (slot_end) st_nxt = HI_ON;
            end
            default: begin
                slot_end = (tmr == ON_LAST);
                if (slot_end) st_nxt = LO_DEAD;
            end
        endcase

        tmr_nxt = slot_end ? '0 : tmr + TMR_W'(1);
        // Only the HI_ON -> LO_DEAD edge may swap the displayed pair.
        commit  = (st == HI_ON) && slot_end && (pend || Ld);

        // Outputs are registered from the next state so SegSel and the
        // forced-off dead window switch on the same edge.
        nxt_hi   = (st_nxt == HI_DEAD) || (st_nxt == HI_ON);
        nxt_on   = (st_nxt == LO_ON)   || (st_nxt == HI_ON);
        dig_show = nxt_hi ? com_hi : com_lo;
        seg_off  = Blank || !nxt_on ||
                   ((st_nxt == HI_ON) && LzBlank && (com_hi == 4'd0));
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            st     <= LO_DEAD;
            tmr    <= '0;
            com_hi <= 4'd0;
            com_lo <= 4'd0;
            pend   <= 1'b0;
            Ack    <= 1'b0;
            SegSel <= 1'b0;
            Seg    <= SEG_OFF;
        end else begin
            st     <= st_nxt;
            tmr    <= tmr_nxt;
            Ack    <= commit;
            SegSel <= nxt_hi;
            Seg    <= seg_off ? SEG_OFF : dig_seg;
            if (commit) begin
                com_hi <= Ld ? DigHi : pend_hi;
                com_lo <= Ld ? DigLo : pend_lo;
                pend   <= 1'b0;
            end else if (Ld) begin
                pend   <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Ld) begin
            pend_hi <= DigHi;
            pend_lo <= DigLo;
        end
    end

endmodule

// File: tb/tb_seg_disp_scheduler.sv
// Bench for seg_disp_scheduler: frame-position reference model plus directed
// and randomized scenarios.
module tb_seg_disp_scheduler;

    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = 2 * RD;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Ld = 1'b0;
    logic       Blank = 1'b0;
    logic       LzBlank = 1'b0;
    logic [3:0] DigHi = 4'd0;
    logic [3:0] DigLo = 4'd0;
    logic       Ack;
    logic       SegSel;
    logic [6:0] Seg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: position within the frame plus digit registers
    int         m_pos = 0;
    logic       m_rst = 1'b1;
    logic       m_ack = 1'b0;
    logic       m_pend = 1'b0;
    logic       m_blank = 1'b0;
    logic       m_lz = 1'b0;
    logic [3:0] m_hi = 4'd0, m_lo = 4'd0, m_phi = 4'd0, m_plo = 4'd0;

    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    seg_disp_scheduler #(.REFRESH_DIV(RD), .DEAD_CYC(DC), .TMR_W(4)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Ld      (Ld),
        .DigHi   (DigHi),
        .DigLo   (DigLo),
        .Blank   (Blank),
        .LzBlank (LzBlank),
        .Ack     (Ack),
        .SegSel  (SegSel),
        .Seg     (Seg)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        string      s;
        logic [6:0] g;
        s = lit[d];
        g = 7'h7F;
        for (int i = 0; i < s.len(); i++) g[6 - (int'(s[i]) - 97)] = 1'b0;
        return g;
    endfunction

    function automatic logic [8:0] expect_out();
        logic sel;
        logic off;
        if (m_rst) return {2'b00, 7'h7F};
        sel = (m_pos >= RD);
        off = m_blank || ((m_pos % RD) < DC) || (sel && m_lz && (m_hi == 4'd0));
        return {m_ack, sel, off ? 7'h7F : glyph(sel ? m_hi : m_lo)};
    endfunction

    task automatic clk_edge();
        logic       rst_s = Rst, ld_s = Ld, bl_s = Blank, lz_s = LzBlank;
        logic [3:0] h = DigHi, l = DigLo;
        @(posedge Clk);
        if (!rst_s) begin
            m_rst = 1'b1; m_pos = 0; m_ack = 1'b0; m_pend = 1'b0;
            m_hi = 4'd0; m_lo = 4'd0;
        end else begin
            m_rst = 1'b0;
            m_ack = (m_pos == FRAME - 1) && (m_pend || ld_s);
            if (m_ack) begin
                m_hi = ld_s ? h : m_phi;
                m_lo = ld_s ? l : m_plo;
                m_pend = 1'b0;
            end else if (ld_s) begin
                m_pend = 1'b1; m_phi = h; m_plo = l;
            end
            m_pos = (m_pos + 1) % FRAME;
            m_blank = bl_s;
            m_lz = lz_s;
        end
        @(negedge Clk);
    endtask

    task automatic align(input int p);
        for (int c = 0; c < FRAME && m_pos != p; c++) clk_edge();
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            clk_edge();
            n_checks++;
            if ({Ack, SegSel, Seg} !== expect_out()) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d got %b want %b", c, {Ack, SegSel, Seg}, expect_out());
            end
        end
        Rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            clk_edge();
            n_checks++;
            if ({Ack, SegSel, Seg} !== expect_out()) begin
                n_fail++;
                $display("FAIL reset_release c=%0d got %b want %b", c, {Ack, SegSel, Seg}, expect_out());
            end
            if (c == 7) begin
                n_checks++;
                if ({SegSel, Seg} !== {1'b1, 7'h7F}) begin
                    n_fail++;
                    $display("FAIL reset_sel_cycle8 got sel=%b seg=%h want sel=1 seg=7f", SegSel, Seg);
                end
            end
        end
    endtask

    task automatic test_load_commit();
        int acks = 0, since = -1;
        align(4);
        Ld = 1'b1; DigHi = 4'h5; DigLo = 4'h1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            clk_edge();
            Ld = 1'b0;
            if (since >= 0) since++;
            if (Ack === 1'b1) begin acks++; since = 0; end
            n_checks++;
            if ({Ack, SegSel, Seg} !== expect_out()) begin
                n_fail++;
                $display("FAIL load_commit c=%0d got %b want %b", c, {Ack, SegSel, Seg}, expect_out());
            end
            if (since == DC || since == RD + DC) begin
                n_checks++;
                if ({SegSel, Seg} !== ((since == DC) ? {1'b0, 7'b1001111} : {1'b1, 7'b0100100})) begin
                    n_fail++;
                    $display("FAIL load_commit_digit since=%0d got sel=%b seg=%b", since, SegSel, Seg);
                end
            end
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL load_commit_acks got %0d want 1", acks);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0, since = -1;
        align(3);
        Ld = 1'b1; DigHi = 4'h8; DigLo = 4'h8;
        clk_edge();
        Ld = 1'b0;
        clk_edge();
        Ld = 1'b1; DigHi = 4'hA; DigLo = 4'h0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            clk_edge();
            Ld = 1'b0;
            if (since >= 0) since++;
            if (Ack === 1'b1) begin acks++; since = 0; end
            n_checks++;
            if ({Ack, SegSel, Seg} !== expect_out()) begin
                n_fail++;
                $display("FAIL back_to_back c=%0d got %b want %b", c, {Ack, SegSel, Seg}, expect_out());
            end
            if (since == DC || since == RD + DC) begin
                n_checks++;
                if (Seg !== ((since == DC) ? 7'b0000001 : 7'b0001000)) begin
                    n_fail++;
                    $display("FAIL back_to_back_digit since=%0d got %b", since, Seg);
                end
            end
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL back_to_back_acks got %0d want 1", acks);
        end
    endtask

    task automatic test_ld_on_commit();
        int acks = 0, since = -1;
        align(5);
        Ld = 1'b1; DigHi = 4'h1; DigLo = 4'h3;
        clk_edge();
        Ld = 1'b0;
        align(FRAME - 1);
        Ld = 1'b1; DigHi = 4'hF; DigLo = 4'h7;
        for (int c = 0; c < 2 * FRAME; c++) begin
            clk_edge();
            Ld = 1'b0;
            if (since >= 0) since++;
            if (Ack === 1'b1) begin acks++; since = 0; end
            n_checks++;
            if ({Ack, SegSel, Seg} !== expect_out()) begin
                n_fail++;
                $display("FAIL ld_on_commit c=%0d got %b want %b", c, {Ack, SegSel, Seg}, expect_out());
            end
            if (since == RD + DC) begin
                n_checks++;
                if (Seg !== 7'b0111000) begin
                    n_fail++;
                    $display("FAIL ld_on_commit_hi got %b want 0111000", Seg);
                end
            end
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL ld_on_commit_acks got %0d want 1", acks);
        end
    endtask

    task automatic test_lzblank();
        int since = -1;
        LzBlank = 1'b1;
        align(2);
        Ld = 1'b1; DigHi = 4'h0; DigLo = 4'h8;
        for (int c = 0; c < 3 * FRAME; c++) begin
            clk_edge();
            Ld = 1'b0;
            if (since >= 0) since++;
            if (Ack === 1'b1) since = 0;
            n_checks++;
            if ({Ack, SegSel, Seg} !== expect_out()) begin
                n_fail++;
                $display("FAIL lzblank c=%0d got %b want %b", c, {Ack, SegSel, Seg}, expect_out());
            end
            if (since == DC || since == RD + DC) begin
                n_checks++;
                if (Seg !== ((since == DC) ? 7'b0000000 : 7'h7F)) begin
                    n_fail++;
                    $display("FAIL lzblank_digit since=%0d got %b", since, Seg);
                end
            end
        end
        LzBlank = 1'b0;
    endtask

    task automatic test_blank();
        int toggles = 0;
        logic prev_sel;
        Blank = 1'b1;
        prev_sel = SegSel;
        for (int c = 0; c < 2 * FRAME; c++) begin
            clk_edge();
            if (SegSel !== prev_sel) toggles++;
            prev_sel = SegSel;
            n_checks++;
            if ({Ack, SegSel, Seg} !== expect_out() || Seg !== 7'h7F) begin
                n_fail++;
                $display("FAIL blank c=%0d got %b want %b", c, {Ack, SegSel, Seg}, expect_out());
            end
        end
        Blank = 1'b0;
        n_checks++;
        if (toggles < 3) begin
            n_fail++;
            $display("FAIL blank_sel_toggles got %0d want >= 3", toggles);
        end
    endtask

    task automatic test_reset_pending();
        int acks = 0;
        align(3);
        Ld = 1'b1; DigHi = 4'h9; DigLo = 4'h6;
        clk_edge();
        Ld = 1'b0;
        Rst = 1'b0;
        for (int c = 0; c < 2 + 2 * FRAME; c++) begin
            clk_edge();
            if (c == 1) Rst = 1'b1;
            if (Ack === 1'b1) acks++;
            n_checks++;
            if ({Ack, SegSel, Seg} !== expect_out()) begin
                n_fail++;
                $display("FAIL reset_pending c=%0d got %b want %b", c, {Ack, SegSel, Seg}, expect_out());
            end
            if (c == 4) begin
                n_checks++;
                if ({SegSel, Seg} !== {1'b0, 7'b0000001}) begin
                    n_fail++;
                    $display("FAIL reset_pending_lo got sel=%b seg=%b want sel=0 seg=0000001", SegSel, Seg);
                end
            end
        end
        n_checks++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL reset_pending_acks got %0d want 0", acks);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            Ld      = ($urandom_range(0, 5) == 0);
            DigHi   = 4'($urandom_range(0, 15));
            DigLo   = 4'($urandom_range(0, 15));
            Blank   = ($urandom_range(0, 9) == 0);
            LzBlank = 1'($urandom_range(0, 1));
            Rst     = ($urandom_range(0, 96) != 0);
            clk_edge();
            n_checks++;
            if ({Ack, SegSel, Seg} !== expect_out()) begin
                n_fail++;
                $display("FAIL random c=%0d got %b want %b", c, {Ack, SegSel, Seg}, expect_out());
            end
        end
        Ld = 1'b0; Blank = 1'b0; LzBlank = 1'b0; Rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_commit();
        test_back_to_back();
        test_ld_on_commit();
        test_lzblank();
        test_blank();
        test_reset_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
